// File: rtl/alu_bitop_pkg.sv
// Shared types and constants for the slice-serial bit-manipulation unit.
package alu_bitop_pkg;

    // Operation encoding as presented on the op port.
    typedef enum logic [1:0] {
        OP_BIT = 2'd0,
        OP_RES = 2'd1,
        OP_SET = 2'd2,
        OP_TGL = 2'd3
    } op_e;

    // Control states of the sequencer.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Bit positions inside the {Z,N,H,C} flag vector.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    // Index width that never collapses to zero bits (a 1-entry range still needs a wire).
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/alu_bitop_slice.sv
// Combinational single-slice operator: modifies at most one bit of the slice
// and reports the value that bit had before modification.
module alu_bitop_slice
    import alu_bitop_pkg::*;
#(
    parameter int SLICE = 4,
    parameter int LW    = clog2_min1(SLICE)
) (
    input  logic [SLICE-1:0] data_i,
    input  logic [LW-1:0]    idx_i,
    input  logic             hit_i,
    input  op_e              op_i,
    output logic [SLICE-1:0] res_o,
    output logic             sel_bit_o
);

    // Pass the slice through, touching only the selected bit when this slice owns it.
    always_comb begin
        res_o     = data_i;
        sel_bit_o = 1'b0;
        if (hit_i) begin
            sel_bit_o = data_i[idx_i];
            case (op_i)
                OP_RES:  res_o[idx_i] = 1'b0;
                OP_SET:  res_o[idx_i] = 1'b1;
                OP_TGL:  res_o[idx_i] = ~data_i[idx_i];
                default: res_o[idx_i] = data_i[idx_i];
            endcase
        end
    end

endmodule

// File: rtl/alu_bitop.sv
// Slice-serial BIT/RES/SET/TGL unit with a start/ready handshake and a
// one-cycle valid strobe. One operation takes NSLICE+2 cycles.
module alu_bitop
    import alu_bitop_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4,
    parameter int BW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [BW-1:0]    bit_sel,
    input  logic [3:0]       flags_in,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = clog2_min1(NSLICE);
    localparam int LW     = clog2_min1(SLICE);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [BW-1:0]    sel_q, sel_d;
    logic [3:0]       flags_q, flags_d;
    logic             acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_out_q, flags_out_d;

    logic [SLICE-1:0] slice_in;
    logic [SLICE-1:0] slice_res;
    logic             slice_bit;
    logic             hit;
    logic [LW-1:0]    lidx;

    // An out-of-range bit_sel never matches any slice, so nothing gets modified.
    assign hit      = (32'(sel_q) < WIDTH) && ((32'(sel_q) / SLICE) == 32'(cnt_q));
    assign lidx     = LW'(32'(sel_q) % SLICE);
    assign slice_in = work_q[32'(cnt_q)*SLICE +: SLICE];

    alu_bitop_slice #(
        .SLICE (SLICE),
        .LW    (LW)
    ) u_slice (
        .data_i    (slice_in),
        .idx_i     (lidx),
        .hit_i     (hit),
        .op_i      (op_q),
        .res_o     (slice_res),
        .sel_bit_o (slice_bit)
    );

    // Handshake outputs are forced low while reset is held.
    assign ready     = (state_q == S_IDLE) && !reset;
    assign valid     = (state_q == S_DONE) && !reset;
    assign result    = result_q;
    assign flags_out = flags_out_q;

    // Next-state and datapath updates for IDLE -> RUN x NSLICE -> DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        work_d      = work_q;
        sel_d       = sel_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        result_d    = result_q;
        flags_out_d = flags_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    work_d  = op_a;
                    sel_d   = bit_sel;
                    flags_d = flags_in;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                work_d[32'(cnt_q)*SLICE +: SLICE] = slice_res;
                acc_d = acc_q | slice_bit;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NSLICE - 1)) begin
                    // Publish on the final slice so the result is stable during DONE.
                    result_d = work_q;
                    result_d[32'(cnt_q)*SLICE +: SLICE] = slice_res;
                    if (op_q == OP_BIT) begin
                        flags_out_d         = 4'b0000;
                        flags_out_d[FLAG_Z] = ~(acc_q | slice_bit);
                        flags_out_d[FLAG_N] = 1'b0;
                        flags_out_d[FLAG_H] = 1'b1;
                        flags_out_d[FLAG_C] = flags_q[FLAG_C];
                    end else begin
                        flags_out_d = flags_q;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset also clears published outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_BIT;
            work_q      <= '0;
            sel_q       <= '0;
            flags_q     <= '0;
            acc_q       <= 1'b0;
            result_q    <= '0;
            flags_out_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            work_q      <= work_d;
            sel_q       <= sel_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            flags_out_q <= flags_out_d;
        end
    end

endmodule

// File: tb/tb_alu_bitop.sv
// Self-checking bench for alu_bitop: three instances (8/4, 16/4, 12/4),
// directed cases, handshake/reset scenarios and randomized operations
// compared against a behavioural model.
module tb_alu_bitop;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start;
    logic [1:0]  op;
    logic [15:0] op_a;
    logic [3:0]  bit_sel;
    logic [3:0]  flags_in;
    logic [2:0]  ready;
    logic [2:0]  valid;
    logic [7:0]  res8;
    logic [15:0] res16;
    logic [11:0] res12;
    logic [3:0]  fo8, fo16, fo12;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_bitop #(.WIDTH(8), .SLICE(4)) dut8 (
        .clk(clk), .reset(reset), .start(start[0]), .op(op), .op_a(op_a[7:0]),
        .bit_sel(bit_sel[2:0]), .flags_in(flags_in), .ready(ready[0]), .valid(valid[0]),
        .result(res8), .flags_out(fo8)
    );

    alu_bitop #(.WIDTH(16), .SLICE(4)) dut16 (
        .clk(clk), .reset(reset), .start(start[1]), .op(op), .op_a(op_a),
        .bit_sel(bit_sel), .flags_in(flags_in), .ready(ready[1]), .valid(valid[1]),
        .result(res16), .flags_out(fo16)
    );

    alu_bitop #(.WIDTH(12), .SLICE(4)) dut12 (
        .clk(clk), .reset(reset), .start(start[2]), .op(op), .op_a(op_a[11:0]),
        .bit_sel(bit_sel), .flags_in(flags_in), .ready(ready[2]), .valid(valid[2]),
        .result(res12), .flags_out(fo12)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: result and {Z,N,H,C} from the operation's definition.
    function automatic logic [19:0] model(input int opc, input logic [15:0] a, input int sel,
                                          input logic [3:0] fin, input int width);
        logic [15:0] m;
        logic [15:0] r;
        logic [3:0]  f;
        logic        b;
        m = (sel < width) ? 16'(1 << sel) : 16'h0000;
        b = ((a & m) != 16'h0000);
        r = a;
        f = fin;
        case (opc)
            0:       f = {~b, 1'b0, 1'b1, fin[0]};
            1:       r = a & ~m;
            2:       r = a | m;
            default: r = a ^ m;
        endcase
        return {f, r};
    endfunction

    function automatic logic [15:0] obs_res(input int w);
        case (w)
            0:       return {8'h00, res8};
            1:       return res16;
            default: return {4'h0, res12};
        endcase
    endfunction

    function automatic logic [3:0] obs_flags(input int w);
        case (w)
            0:       return fo8;
            1:       return fo16;
            default: return fo12;
        endcase
    endfunction

    // One full transaction on instance w, checking latency, result and flags.
    task automatic run_op(input int w, input int opc, input logic [15:0] a, input int sel,
                          input logic [3:0] fin);
        int          width;
        int          ns;
        logic [15:0] mask;
        logic [19:0] exp;
        logic        early;
        width = (w == 0) ? 8 : ((w == 1) ? 16 : 12);
        ns    = width / 4;
        mask  = 16'((1 << width) - 1);
        exp   = model(opc, a & mask, sel, fin, width);
        @(negedge clk);
        for (int i = 0; i < 20 && !ready[w]; i++) @(negedge clk);
        check("ready_before_start", 32'(ready[w]), 32'd1);
        op       = 2'(opc);
        op_a     = a;
        bit_sel  = 4'(sel);
        flags_in = fin;
        start[w] = 1'b1;
        @(posedge clk);
        #1;
        start[w] = 1'b0;
        op_a     = 16'($urandom);
        op       = 2'($urandom);
        bit_sel  = 4'($urandom);
        flags_in = 4'($urandom);
        early    = 1'b0;
        for (int c = 1; c <= ns; c++) begin
            @(negedge clk);
            if (valid[w] || ready[w]) early = 1'b1;
        end
        check("busy_no_valid_ready", 32'(early), 32'd0);
        @(negedge clk);
        check("valid_at_latency", 32'(valid[w]), 32'd1);
        check("ready_low_at_valid", 32'(ready[w]), 32'd0);
        check("result", 32'(obs_res(w)), 32'(exp[15:0]));
        check("flags", 32'(obs_flags(w)), 32'(exp[19:16]));
        @(negedge clk);
        check("ready_after_done", 32'(ready[w]), 32'd1);
        check("valid_one_cycle", 32'(valid[w]), 32'd0);
        $display("txn w=%0d op=%0d a=0x%0h sel=%0d fin=%b -> res=0x%0h flags=%b (exp 0x%0h %b)",
                 width, opc, a & mask, sel, fin, obs_res(w), obs_flags(w), exp[15:0], exp[19:16]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        int prev;
        int first;
        logic gap_bad;
        logic overlap;
        logic [15:0] cap;

        reset    = 1'b1;
        start    = 3'b000;
        op       = 2'd0;
        op_a     = 16'h0000;
        bit_sel  = 4'h0;
        flags_in = 4'h0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ready_low", 32'(ready), 32'd0);
        check("rst_valid_low", 32'(valid), 32'd0);
        check("rst_result", 32'(res8), 32'd0);
        check("rst_flags", 32'(fo8), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_release", 32'(ready), 32'b111);

        // Directed cases.
        for (int n = 7; n >= 0; n--) run_op(0, 1, 16'h00FF, n, 4'b0000);
        run_op(0, 0, 16'h0000, 3, 4'b0001);
        run_op(0, 0, 16'h00A5, 7, 4'b0001);
        run_op(0, 2, 16'h00A5, 1, 4'b0110);
        run_op(0, 3, 16'h00A5, 0, 4'b1001);

        // start pulsed in the two cycles after acceptance must be ignored.
        @(negedge clk);
        op = 2'd1; op_a = 16'h00F0; bit_sel = 4'd4; flags_in = 4'b0000;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        op_a = 16'h000F;
        nv = 0; first = -1; cap = 16'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (valid[0]) begin
                nv++;
                if (first < 0) first = c;
                cap = {8'h00, res8};
            end
            if (c == 2) start[0] = 1'b0;
        end
        check("ignore_start_valids", 32'(nv), 32'd1);
        check("ignore_start_valid_cycle", 32'(first), 32'd3);
        check("ignore_start_result", 32'(cap), 32'h00E0);
        $display("txn handshake-ignore valids=%0d first=%0d res=0x%0h", nv, first, cap);

        // start held high: back-to-back issue every NSLICE+2 cycles.
        @(negedge clk);
        op = 2'd2; op_a = 16'h0000; bit_sel = 4'd2; flags_in = 4'b1010;
        start[0] = 1'b1;
        nv = 0; prev = -1; first = -1; gap_bad = 1'b0; overlap = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (ready[0] && valid[0]) overlap = 1'b1;
            if (valid[0]) begin
                if (prev >= 0 && (c - prev) != 4) gap_bad = 1'b1;
                if (first < 0) first = c;
                if (res8 !== 8'h04 || fo8 !== 4'b1010) gap_bad = 1'b1;
                prev = c;
                nv++;
            end
        end
        start[0] = 1'b0;
        check("held_start_valid_count", 32'(nv), 32'd4);
        check("held_start_first_valid", 32'(first), 32'd3);
        check("held_start_spacing_data", 32'(gap_bad), 32'd0);
        check("held_start_no_overlap", 32'(overlap), 32'd0);
        $display("txn held-start valids=%0d first=%0d", nv, first);

        // Reset in a RUN cycle aborts and clears outputs.
        run_op(0, 1, 16'h00FF, 0, 4'b0101);
        @(negedge clk);
        op = 2'd2; op_a = 16'h0011; bit_sel = 4'd5; flags_in = 4'b1111;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_run_ready_low", 32'(ready[0]), 32'd0);
        check("rst_run_valid_low", 32'(valid[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_run_ready_next", 32'(ready[0]), 32'd1);
        check("rst_run_result_zero", 32'(res8), 32'd0);
        check("rst_run_flags_zero", 32'(fo8), 32'd0);
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (valid[0]) nv++;
        end
        check("rst_run_no_valid", 32'(nv), 32'd0);
        $display("txn reset-in-run valids_after=%0d res=0x%0h", nv, res8);

        // Wider and non-power-of-two widths.
        run_op(1, 1, 16'hFFFF, 13, 4'b0000);
        run_op(2, 0, 16'h0ABC, 13, 4'b0001);
        run_op(2, 3, 16'h0ABC, 14, 4'b0000);
        run_op(2, 3, 16'h0ABC, 11, 4'b0000);

        // Randomized operations.
        for (int i = 0; i < 30; i++)
            run_op(0, int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 7)), 4'($urandom));
        for (int i = 0; i < 10; i++)
            run_op(1, int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 15)), 4'($urandom));
        for (int i = 0; i < 12; i++)
            run_op(2, int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 15)), 4'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
